// File: rtl/hpdcache_wrr_pkt_arb.sv
// Weighted round-robin packet arbiter. Grants one of N requesters per packet,
// holds the grant under backpressure, locks it until the last beat, and lets
// a requester keep priority for up to weight consecutive packets.
module hpdcache_wrr_pkt_arb #(
  parameter int unsigned N        = 4,
  parameter int unsigned WEIGHT_W = 4,
  localparam int unsigned IDX_W   = $clog2(N)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [N-1:0]          req_i,
  input  logic                  last_i,
  input  logic                  ready_i,
  input  logic [N*WEIGHT_W-1:0] weight_i,
  output logic [N-1:0]          gnt_o,
  output logic [IDX_W-1:0]      gnt_idx_o,
  output logic                  locked_o
);

  typedef enum logic [1:0] {StArb, StHold, StLock} fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]        gnt_q, gnt_d;

  logic [N-1:0]        rr_gnt;
  logic                rr_found;
  logic [IDX_W-1:0]    rr_pos;
  logic [IDX_W-1:0]    gnt_idx;
  logic                credit;
  logic [WEIGHT_W-1:0] w_raw, w_eff, cnt_inc;

  // Round-robin scan of req_i starting at ptr_q, wrapping modulo N.
  always_comb begin
    rr_gnt   = '0;
    rr_found = 1'b0;
    rr_pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      rr_pos = IDX_W'((32'(ptr_q) + i) % N);
      if (!rr_found && req_i[rr_pos]) begin
        rr_found       = 1'b1;
        rr_gnt[rr_pos] = 1'b1;
      end
    end
  end

  // Grant output: live round-robin in ARB, held grant otherwise; forced idle in reset.
  always_comb begin
    gnt_o    = '0;
    locked_o = 1'b0;
    if (!rst_i) begin
      gnt_o    = (fsm_q == StArb) ? rr_gnt : gnt_q;
      locked_o = (fsm_q == StLock);
    end
  end

  // One-hot grant to binary index.
  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (gnt_o[i]) gnt_idx = IDX_W'(i);
    end
  end

  assign gnt_idx_o = gnt_idx;

  // Next-state logic: packet FSM plus weighted credit update on end of packet.
  always_comb begin
    fsm_d   = fsm_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    credit  = 1'b0;

    case (fsm_q)
      StArb: begin
        if (|rr_gnt) begin
          if (!ready_i) begin
            fsm_d = StHold;
            gnt_d = rr_gnt;
          end else if (!last_i) begin
            fsm_d = StLock;
            gnt_d = rr_gnt;
          end else begin
            credit = 1'b1;
          end
        end
      end
      StHold: begin
        if (ready_i) begin
          if (last_i) begin
            fsm_d  = StArb;
            credit = 1'b1;
          end else begin
            fsm_d = StLock;
          end
        end
      end
      StLock: begin
        if (ready_i && last_i) begin
          fsm_d  = StArb;
          credit = 1'b1;
        end
      end
      default: fsm_d = StArb;
    endcase

    // A zero weight behaves as one packet per turn.
    w_raw   = weight_i[32'(gnt_idx) * WEIGHT_W +: WEIGHT_W];
    w_eff   = (w_raw == '0) ? WEIGHT_W'(1) : w_raw;
    cnt_inc = (gnt_idx == owner_q) ? cnt_q + WEIGHT_W'(1) : WEIGHT_W'(1);

    if (credit) begin
      owner_d = gnt_idx;
      if (cnt_inc >= w_eff) begin
        ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1);
        cnt_d = '0;
      end else begin
        ptr_d = gnt_idx;
        cnt_d = cnt_inc;
      end
    end
  end

  // State registers with synchronous reset; reset abandons any open packet.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= StArb;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
    end
  end

`ifndef SYNTHESIS
  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(gnt_o));
  a_no_withdraw : assert property (@(posedge clk_i) disable iff (rst_i)
    (fsm_q != StArb) |-> (|(req_i & gnt_q)));
  a_no_spurious : assert property (@(posedge clk_i) disable iff (rst_i)
    ((fsm_q == StArb) && (req_i == '0)) |-> (gnt_o == '0));
`endif

endmodule

// File: tb/tb_hpdcache_wrr_pkt_arb.sv
// Bench for the weighted round-robin packet arbiter: directed scenarios with
// literal expectations, then randomized traffic against a packet-level model.
module tb_hpdcache_wrr_pkt_arb;

  localparam int unsigned N  = 4;
  localparam int unsigned WW = 4;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic            last;
  logic            ready;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    gnt;
  logic [IW-1:0]   gnt_idx;
  logic            locked;

  hpdcache_wrr_pkt_arb #(
    .N        (N),
    .WEIGHT_W (WW)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .req_i     (req),
    .last_i    (last),
    .ready_i   (ready),
    .weight_i  (weight),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .locked_o  (locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Packet-level model: priority pointer, credit owner/count, current holder.
  int m_ptr   = 0;
  int m_owner = 0;
  int m_cnt   = 0;
  int m_held  = -1;  // requester owning an open or stalled packet, -1 if none
  int m_mid   = 0;   // 1 once a beat of the open packet has been accepted

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, check outputs against the model (and an optional literal),
  // then advance the model by what the rising edge will do.
  task automatic step(input logic [N-1:0] r, input logic l, input logic rd, input logic rs,
                      input bit lit_en, input logic [N-1:0] lit_gnt, output int done);
    int g;
    int j;
    int w;
    int c;
    logic [N-1:0] e;
    req = r; last = l; ready = rd; rst = rs;
    done = -1;
    #2;
    g = -1;
    if (!rs) begin
      if (m_held >= 0) g = m_held;
      else begin
        for (int i = 0; i < N; i++) begin
          j = (m_ptr + i) % N;
          if (g < 0 && r[j]) g = j;
        end
      end
    end
    e = '0;
    if (g >= 0) e[g] = 1'b1;
    chk("gnt", 32'(gnt), 32'(e));
    chk("gnt_idx", 32'(gnt_idx), (g < 0) ? 32'd0 : 32'(g));
    chk("locked", 32'(locked), 32'(!rs && m_held >= 0 && m_mid == 1));
    if (lit_en) chk("plan_gnt", 32'(gnt), 32'(lit_gnt));

    if (rs) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_held = -1; m_mid = 0;
    end else if (g >= 0) begin
      if (rd && l) begin
        w = int'(weight[g*WW +: WW]);
        if (w == 0) w = 1;
        c = (g == m_owner) ? m_cnt + 1 : 1;
        if (c >= w) begin
          m_ptr = (g + 1) % N;
          m_cnt = 0;
        end else begin
          m_ptr = g;
          m_cnt = c;
        end
        m_owner = g;
        m_held  = -1;
        m_mid   = 0;
        done    = g;
      end else begin
        m_held = g;
        if (rd) m_mid = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    logic [N-1:0] pend;
    logic rs;
    logic [N-1:0] wseq0 [8];
    logic [N-1:0] wseq1 [4];
    logic [N-1:0] rot [5];

    rst = 1'b1; req = '0; last = 1'b0; ready = 1'b0; weight = 16'h1111;

    // Reset with everyone requesting, then plain rotation.
    step(4'b1111, 1, 1, 1, 1, 4'b0000, d);
    step(4'b1111, 1, 1, 1, 1, 4'b0000, d);
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    foreach (rot[i]) step(4'b1111, 1, 1, 0, 1, rot[i], d);

    // Weighting: requester 0 gets three packets per turn, then weight 0 acts as 1.
    step(4'b0000, 0, 0, 1, 1, 4'b0000, d);
    weight = 16'h1113;
    wseq0 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
    foreach (wseq0[i]) step(4'b0011, 1, 1, 0, 1, wseq0[i], d);
    weight = 16'h1110;
    wseq1 = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    foreach (wseq1[i]) step(4'b0011, 1, 1, 0, 1, wseq1[i], d);

    // Backpressure hold: grant stays put while a lower index arrives.
    weight = 16'h1111;
    step(4'b0000, 0, 0, 1, 1, 4'b0000, d);
    step(4'b0110, 1, 0, 0, 1, 4'b0010, d);
    step(4'b0111, 1, 0, 0, 1, 4'b0010, d);
    step(4'b0111, 1, 0, 0, 1, 4'b0010, d);
    step(4'b0111, 1, 1, 0, 1, 4'b0010, d);
    step(4'b0101, 1, 1, 0, 1, 4'b0100, d);

    // Four-beat packet lock.
    step(4'b0000, 0, 0, 1, 1, 4'b0000, d);
    step(4'b0010, 0, 1, 0, 1, 4'b0010, d);
    chk("lock_beat1", 32'(locked), 32'd1);
    step(4'b0011, 0, 1, 0, 1, 4'b0010, d);
    step(4'b0011, 0, 1, 0, 1, 4'b0010, d);
    step(4'b0011, 1, 1, 0, 1, 4'b0010, d);
    step(4'b0001, 1, 1, 0, 1, 4'b0001, d);

    // Wrap-around from pointer 3, skipping idle requesters.
    step(4'b0000, 0, 0, 1, 1, 4'b0000, d);
    step(4'b0100, 1, 1, 0, 1, 4'b0100, d);
    step(4'b0101, 1, 1, 0, 1, 4'b0001, d);
    step(4'b0101, 1, 1, 0, 1, 4'b0100, d);

    // Reset in the middle of a locked packet.
    step(4'b0000, 0, 0, 1, 1, 4'b0000, d);
    step(4'b0100, 0, 1, 0, 1, 4'b0100, d);
    step(4'b0100, 0, 1, 1, 1, 4'b0000, d);
    step(4'b0101, 1, 1, 0, 1, 4'b0001, d);

    // Randomized traffic: requesters stay up until their last beat is accepted.
    pend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 15) == 0) weight = (N*WW)'($urandom);
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) pend[k] = 1'b1;
      end
      rs = ($urandom_range(0, 99) == 0);
      step(pend, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0, rs, 0, 4'b0000, d);
      if (d >= 0) pend[d] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hpdcache_wrr_pkt_arb.md
Name: hpdcache_wrr_pkt_arb

Overview:
- Weighted round-robin arbiter. It shares one downstream resource (for example a memory request port or a refill/write-buffer channel) between N requesters.
- Arbitration is per packet. A packet is one or more beats and ends with the beat that carries last_i.
- The grant is held stable under backpressure and locked until the packet ends. Each requester may then keep priority for up to weight_i consecutive packets before the round-robin pointer advances.
- Sits in front of a shared resource, in place of a plain fixed-priority arbiter, where fairness and burst atomicity are required.

Parameters:
- N, 4, number of requesters (N >= 2).
- WEIGHT_W, 4, width of each per-requester weight field.
- IDX_W, $clog2(N), width of the grant index (derived; not overridden).

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  N  request vector. A requester keeps its bit high until its last beat is accepted.
- last_i  in  1  the beat currently presented by the granted requester is the last of its packet.
- ready_i  in  1  the resource accepts the presented beat this cycle.
- weight_i  in  N*WEIGHT_W  weight of requester k in bits [k*WEIGHT_W +: WEIGHT_W]. The value 0 is treated as 1.
- gnt_o  out  N  one-hot-or-zero grant.
- gnt_idx_o  out  IDX_W  index of the granted bit; 0 when gnt_o == 0.
- locked_o  out  1  high while in the LOCK state (mid-packet).

Behaviour:
- Internal state:
  - fsm_q: ARB, HOLD or LOCK.
  - ptr_q [IDX_W]: index of the highest-priority requester.
  - owner_q [IDX_W]: requester that completed the most recent packet.
  - cnt_q [WEIGHT_W]: number of packets owner_q has completed while keeping priority.
  - gnt_q [N]: the held grant.
- Reset, applied while rst_i = 1:
  - Next state: fsm_q = ARB, ptr_q = 0, owner_q = 0, cnt_q = 0, gnt_q = 0.
  - gnt_o = 0, gnt_idx_o = 0 and locked_o = 0 combinationally for as long as rst_i is high.
  - Reset applied mid-packet or mid-hold abandons the packet; no ptr or cnt update is made for it.
- Grant computation:
  - rr_gnt = the first set bit of req_i, scanning ptr_q, ptr_q+1, ..., wrapping modulo N.
  - In ARB, gnt_o = rr_gnt, with zero-latency combinational output.
  - In HOLD and LOCK, gnt_o = gnt_q, independent of req_i.
- Definitions:
  - acc = (|gnt_o) & ready_i.
  - eop = acc & last_i.
- Transitions:
  - ARB, no request: stay in ARB.
  - ARB, |req_i and !ready_i: go to HOLD; gnt_q <= rr_gnt.
  - ARB, acc and !last_i: go to LOCK; gnt_q <= rr_gnt.
  - ARB, eop: stay in ARB; apply the credit update.
  - HOLD, !ready_i: stay in HOLD.
  - HOLD, acc and !last_i: go to LOCK.
  - HOLD, eop: go to ARB; apply the credit update.
  - LOCK, eop: go to ARB; apply the credit update.
  - LOCK, otherwise: stay in LOCK, including on non-last accepted beats.
- Credit update when requester k completes a packet (eop):
  - w = (weight_i[k] == 0) ? 1 : weight_i[k], sampled in the eop cycle.
  - c = (k == owner_q) ? cnt_q + 1 : 1. c never exceeds 2^WEIGHT_W - 1, so no overflow.
  - If c >= w: ptr_q <= (k + 1) mod N, cnt_q <= 0.
  - Otherwise: ptr_q <= k, cnt_q <= c.
  - In both cases owner_q <= k.
  - If weight_i is lowered below the current cnt_q, the next eop of that requester advances ptr_q.
- Back-to-back packets: the eop cycle returns the FSM to ARB, so a new grant is available on the next cycle. There are no idle bubbles.
- Assertions:
  - gnt_o is $onehot0.
  - In HOLD and LOCK, req_i & gnt_q must be nonzero; a requester may not withdraw.
  - gnt_o is never nonzero while req_i == 0 in ARB.

Test Plan:
- Reset and basic rotation:
  - Stimulus: rst_i = 1 with req_i = 4'b1111 → gnt_o = 0.
  - Then release reset; all weights 1, ready_i = 1, last_i = 1.
  - Required: gnt_o = 0001, 0010, 0100, 1000, 0001 on consecutive cycles.
- Weighting:
  - Stimulus: weight0 = 3, weight1 = 1, req_i = 0011, single-beat packets, ready_i = 1.
  - Required grant index sequence: 0,0,0,1,0,0,0,1.
  - Setting weight0 = 0 changes the sequence to 0,1,0,1.
- Backpressure hold:
  - Stimulus: req_i = 0110, ready_i = 0 for 3 cycles; req_i bit0 rises in cycle 2.
  - Required: gnt_o = 0010 in all 3 cycles, fsm_q = HOLD.
  - Then ready_i = 1 with last_i = 1: next grant is 0100 (ptr_q = 2).
- Packet lock:
  - Stimulus: requester 1 sends a 4-beat packet, last on beat 4, ready_i = 1; req_i bit0 is asserted from beat 2.
  - Required: gnt_o = 0010 on all 4 beats; locked_o = 1 on beats 2-4 and 0 on beat 1.
  - Next cycle: gnt_o = 0001.
- Wrap-around and skipping:
  - Stimulus: ptr_q = 3 with req_i = 0101.
  - Required: grant 0001 (wraps past idle bit 3), then 0100.
- Reset mid-LOCK:
  - Stimulus: assert rst_i during beat 2 of a packet from requester 2.
  - Required: the next cycle is in ARB with ptr_q = 0 and cnt_q = 0; with req_i = 0101, gnt_o = 0001.
